// File: rtl/ddr3_rx_lane_align.sv
// DDR3 PHY receive lane training: bit-slip and delay-tap search for word alignment.
// Drives the input IOD slip/delay controls and forwards aligned data once locked.
`timescale 1ns/1ps
module ddr3_rx_lane_align #(
  parameter int RX_WIDTH = 8,
  parameter logic [RX_WIDTH-1:0] PATTERN = 8'b0000_1111,
  parameter int MATCH_COUNT = 16,
  parameter int SLIP_WAIT = 4,
  parameter int MAX_TAPS = 127
) (
  input  logic                FAB_CLK,
  input  logic                ARST_N,
  input  logic                start,
  input  logic [RX_WIDTH-1:0] RX_DATA,
  input  logic                DELAY_LINE_OUT_OF_RANGE,
  output logic                RX_BIT_SLIP,
  output logic                DELAY_LINE_LOAD,
  output logic                DELAY_LINE_MOVE,
  output logic                DELAY_LINE_DIRECTION,
  output logic                busy,
  output logic                locked,
  output logic                fail,
  output logic [2:0]          slip_count,
  output logic [6:0]          tap_count,
  output logic [RX_WIDTH-1:0] data_out,
  output logic                data_valid
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, CHECK, SLIP, MOVE, LOCKED, FAIL
  } state_t;

  state_t     state, state_n;
  logic [3:0] wait_q;
  logic [7:0] match_q;
  logic       oor_q;
  logic       hit;
  logic       last_match;
  logic       dead_end;

  assign hit        = (RX_DATA == PATTERN);
  assign last_match = (match_q == 8'(MATCH_COUNT - 1));
  assign dead_end   = (tap_count == 7'(MAX_TAPS)) ||
                      DELAY_LINE_OUT_OF_RANGE;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (start) state_n = LOAD;
      LOAD:   state_n = SETTLE;
      SETTLE: if (wait_q == 4'(SLIP_WAIT - 1)) state_n = CHECK;
      CHECK: begin
        if (hit) begin
          if (last_match) state_n = LOCKED;
        end else if (oor_q) begin
          state_n = FAIL;
        end else if (slip_count != 3'd7) begin
          state_n = SLIP;
        end else if (dead_end) begin
          state_n = FAIL;
        end else begin
          state_n = MOVE;
        end
      end
      SLIP:   state_n = SETTLE;
      MOVE:   state_n = SETTLE;
      LOCKED: if (start) state_n = LOAD;
      FAIL:   if (start) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  // Every control output is registered from the next state so pulses are glitch-free.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state                <= IDLE;
      RX_BIT_SLIP          <= 1'b0;
      DELAY_LINE_LOAD      <= 1'b0;
      DELAY_LINE_MOVE      <= 1'b0;
      DELAY_LINE_DIRECTION <= 1'b0;
      busy                 <= 1'b0;
      locked               <= 1'b0;
      fail                 <= 1'b0;
      slip_count           <= '0;
      tap_count            <= '0;
      data_out             <= '0;
      data_valid           <= 1'b0;
      wait_q               <= '0;
      match_q              <= '0;
      oor_q                <= 1'b0;
    end else begin
      state                <= state_n;
      RX_BIT_SLIP          <= (state_n == SLIP);
      DELAY_LINE_LOAD      <= (state_n == LOAD);
      DELAY_LINE_MOVE      <= (state_n == MOVE);
      DELAY_LINE_DIRECTION <= (state_n == MOVE);
      busy   <= (state_n == LOAD) || (state_n == SETTLE) ||
                (state_n == CHECK) || (state_n == SLIP) ||
                (state_n == MOVE);
      locked <= (state_n == LOCKED);
      fail   <= (state_n == FAIL);
      wait_q  <= (state == SETTLE) ? wait_q + 4'd1 : 4'd0;
      match_q <= (state == CHECK && hit) ? match_q + 8'd1 : 8'd0;
      if (state_n == LOAD) begin
        slip_count <= '0;
        tap_count  <= '0;
        oor_q      <= 1'b0;
      end else begin
        if (state == SLIP && slip_count != 3'd7)
          slip_count <= slip_count + 3'd1;
        if (state == MOVE) begin
          slip_count <= '0;
          if (tap_count != 7'(MAX_TAPS))
            tap_count <= tap_count + 7'd1;
        end
        if ((state == SETTLE || state == CHECK) &&
            DELAY_LINE_OUT_OF_RANGE)
          oor_q <= 1'b1;
      end
      if (state == LOCKED) data_out <= RX_DATA;
      data_valid <= (state == LOCKED) && (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_ddr3_rx_lane_align.sv
// Directed bench for ddr3_rx_lane_align with a rotating-pattern IOD model.
// Vector table covers slip alignment; hand sequences cover fail, range and reset.
`timescale 1ns/1ps
module tb_ddr3_rx_lane_align;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N = 1'b0;
  logic       start = 1'b0;
  logic [7:0] RX_DATA;
  logic       oor = 1'b0;
  logic       RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE;
  logic       DELAY_LINE_DIRECTION;
  logic       busy, locked, fail, data_valid;
  logic [2:0] slip_count;
  logic [6:0] tap_count;
  logic [7:0] data_out;

  ddr3_rx_lane_align dut (
    .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .start(start),
    .RX_DATA(RX_DATA), .DELAY_LINE_OUT_OF_RANGE(oor),
    .RX_BIT_SLIP(RX_BIT_SLIP), .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
    .busy(busy), .locked(locked), .fail(fail),
    .slip_count(slip_count), .tap_count(tap_count),
    .data_out(data_out), .data_valid(data_valid)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  localparam logic [7:0] PAT = 8'h0F;

  int errors = 0;
  int checks = 0;

  int slips = 0, loads = 0, moves = 0, cyc = 0;
  int last_pulse = -100;
  int space_bad = 0, excl_bad = 0, dir_bad = 0;
  int mark_s, mark_l, mark_m;
  int rot_base = 0;
  int rx_mode = 0;
  logic [7:0] rnd = 8'h00;

  function automatic logic [7:0] rotl(input logic [7:0] p, input int r);
    logic [15:0] t;
    t = {p, p} << (r % 8);
    return t[15:8];
  endfunction

  always_comb begin
    RX_DATA = 8'h33;
    if (rx_mode == 0)
      RX_DATA = rotl(PAT, (rot_base + slips - mark_s) & 7);
    else if (rx_mode == 2)
      RX_DATA = rnd;
  end

  always @(posedge FAB_CLK) begin
    cyc <= cyc + 1;
    if (RX_BIT_SLIP) slips <= slips + 1;
    if (DELAY_LINE_LOAD) loads <= loads + 1;
    if (DELAY_LINE_MOVE) begin
      moves <= moves + 1;
      if (!DELAY_LINE_DIRECTION) dir_bad <= dir_bad + 1;
    end
    if (RX_BIT_SLIP || DELAY_LINE_LOAD || DELAY_LINE_MOVE) begin
      if (int'(RX_BIT_SLIP) + int'(DELAY_LINE_LOAD) +
          int'(DELAY_LINE_MOVE) > 1)
        excl_bad <= excl_bad + 1;
      if (cyc - last_pulse < 5) space_bad <= space_bad + 1;
      last_pulse <= cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic mark;
    mark_s = slips;
    mark_l = loads;
    mark_m = moves;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int maxc, output int n);
    n = 0;
    while (!(locked || fail) && n < maxc) begin
      tick();
      n++;
    end
    if (!(locked || fail)) begin
      errors++;
      checks++;
      $display("FAIL wait_end: timeout after %0d cycles", n);
    end
  endtask

  function automatic int outs_all();
    return int'({RX_BIT_SLIP, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                 DELAY_LINE_DIRECTION, busy, locked, fail,
                 slip_count, tap_count, data_out, data_valid});
  endfunction

  typedef struct {
    int rot;
    bit restart;
    int exp_slips;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int n;
    tbl[0] = '{rot: 3, restart: 1'b1, exp_slips: 5};
    tbl[1] = '{rot: 0, restart: 1'b0, exp_slips: 0};
    tbl[2] = '{rot: 5, restart: 1'b0, exp_slips: 3};
    tbl[3] = '{rot: 7, restart: 1'b0, exp_slips: 1};
    tbl[4] = '{rot: 1, restart: 1'b0, exp_slips: 7};
    mark();

    // Reset with random input data
    rx_mode = 2;
    rnd = 8'($urandom);
    repeat (3) tick();
    chk("reset_outputs", outs_all(), 0);
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (2) tick();

    // Aligned pattern: lock latency and data path
    rx_mode = 0;
    rot_base = 0;
    mark();
    pulse_start();
    chk("busy_after_start", int'(busy), 1);
    wait_end(200, n);
    chk("lock_latency_ok", int'(n >= 21 && n <= 23), 1);
    chk("aligned_locked", int'(locked), 1);
    chk("aligned_busy", int'(busy), 0);
    chk("aligned_loads", loads - mark_l, 1);
    chk("aligned_slips", slips - mark_s, 0);
    chk("valid_latency", int'(data_valid), 0);
    tick();
    chk("valid_next", int'(data_valid), 1);
    chk("data_out", int'(data_out), int'(PAT));

    // Rotated patterns, retrain from lock each time
    for (int i = 0; i < 5; i++) begin
      rot_base = tbl[i].rot;
      mark();
      pulse_start();
      chk("drop_locked", int'(locked), 0);
      chk("drop_valid", int'(data_valid), 0);
      if (tbl[i].restart) begin
        repeat (3) tick();
        pulse_start();
      end
      wait_end(500, n);
      chk("tbl_locked", int'(locked), 1);
      chk("tbl_slip_pulses", slips - mark_s, tbl[i].exp_slips);
      chk("tbl_slip_count", int'(slip_count), tbl[i].exp_slips);
      chk("tbl_tap_count", int'(tap_count), 0);
      chk("tbl_loads", loads - mark_l, 1);
    end

    // Never matches: full tap sweep then fail
    rx_mode = 1;
    mark();
    pulse_start();
    wait_end(20000, n);
    chk("sweep_fail", int'(fail), 1);
    chk("sweep_locked", int'(locked), 0);
    chk("sweep_busy", int'(busy), 0);
    chk("sweep_tap_count", int'(tap_count), 127);
    chk("sweep_moves", moves - mark_m, 127);
    chk("sweep_slips", slips - mark_s, 128 * 7);
    chk("sweep_valid", int'(data_valid), 0);

    // Delay line hits its limit at tap 10
    mark();
    pulse_start();
    n = 0;
    while (moves - mark_m < 10 && n < 5000) begin
      tick();
      n++;
    end
    oor = 1'b1;
    wait_end(2000, n);
    chk("oor_fail", int'(fail), 1);
    chk("oor_tap_count", int'(tap_count), 10);
    repeat (20) tick();
    chk("oor_moves", moves - mark_m, 10);
    oor = 1'b0;

    // Asynchronous reset during a slip pulse
    mark();
    pulse_start();
    n = 0;
    while (!RX_BIT_SLIP && n < 200) begin
      tick();
      n++;
    end
    chk("saw_slip", int'(RX_BIT_SLIP), 1);
    #2 ARST_N = 1'b0;
    #1 chk("async_reset_outputs", outs_all(), 0);
    @(negedge FAB_CLK);
    ARST_N = 1'b1;
    tick();
    rx_mode = 0;
    rot_base = 0;
    mark();
    pulse_start();
    wait_end(200, n);
    chk("rst_relock", int'(locked), 1);
    chk("rst_slip_count", int'(slip_count), 0);
    chk("rst_tap_count", int'(tap_count), 0);

    tick();
    chk("pulse_spacing", space_bad, 0);
    chk("pulse_exclusive", excl_bad, 0);
    chk("move_direction", dir_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
